// File: rtl/instr_encoder_loader_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader_if
// Bundles the field-set handshake, address-load control and byte-write memory
// bus of the RV32I instruction encoder/loader.
//   slave  : the encoder/loader itself
//   master : the program source plus the memory (drives fields, load, mem_ready)
// Signals:
//   in_valid/in_ready          field-set handshake
//   opCode..immediateExtd      decoded-style instruction fields
//   load_en/load_addr          load a new (word-aligned) write address
//   mem_we/mem_ready           byte write strobe / memory accept
//   mem_addr/mem_wdata         byte address / byte data
//   instr_out                  last encoded instruction
//   done/err                   one-cycle pulses: instruction written / rejected
//   instr_count                instructions written, modulo 2^16
// ----------------------------------------------------------------------------
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        opCode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rd_addr;
   logic [4:0]        rs1_addr;
   logic [4:0]        rs2_addr;
   logic [31:0]       immediateExtd;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [31:0]       instr_out;
   logic              done;
   logic              err;
   logic [15:0]       instr_count;

   modport slave (
      input  in_valid, opCode, funct3, funct7, rd_addr, rs1_addr, rs2_addr,
             immediateExtd, load_en, load_addr, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, instr_out, done, err,
             instr_count
   );

   modport master (
      output in_valid, opCode, funct3, funct7, rd_addr, rs1_addr, rs2_addr,
             immediateExtd, load_en, load_addr, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, instr_out, done, err,
             instr_count
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
// Packs a decoded-style RV32I field set into a 32-bit instruction and writes it
// byte-serially, little-endian, into byte-addressed memory at an
// auto-incrementing word-aligned address. Used to preload test programs.
// Parameters:
//   ADDR_W     memory address width
//   BASE_ADDR  write address after reset
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        instr_encoder_loader_if.slave (handshake, fields, memory bus)
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   instr_encoder_loader_if.slave   bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [7:0]        mem_wdata_reg;
   logic              mem_we_reg;
   logic [31:0]       instr_out_reg;
   logic              done_reg;
   logic              err_reg;
   logic [15:0]       instr_count_reg;

   logic [31:0]       imm;
   logic [31:0]       enc_word;
   logic              enc_legal;
   logic [7:0]        instr_byte [4];

   assign imm = bus.immediateExtd;

   // Little-endian byte lanes of the captured instruction.
   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign instr_byte[gi] = instr_out_reg[8*gi +: 8];
   end

   // Field packing per instruction format; unknown opcodes are flagged.
   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      case (bus.opCode)
         OP_R:
            enc_word = {bus.funct7, bus.rs2_addr, bus.rs1_addr, bus.funct3,
                        bus.rd_addr, bus.opCode};
         OP_IMM: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)
               enc_word = {bus.funct7, imm[4:0], bus.rs1_addr, bus.funct3,
                           bus.rd_addr, bus.opCode};
            else
               enc_word = {imm[11:0], bus.rs1_addr, bus.funct3,
                           bus.rd_addr, bus.opCode};
         end
         OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:
            enc_word = {imm[11:0], bus.rs1_addr, bus.funct3,
                        bus.rd_addr, bus.opCode};
         OP_STORE:
            enc_word = {imm[11:5], bus.rs2_addr, bus.rs1_addr, bus.funct3,
                        imm[4:0], bus.opCode};
         OP_BRANCH:
            enc_word = {imm[12], imm[10:5], bus.rs2_addr, bus.rs1_addr,
                        bus.funct3, imm[4:1], imm[11], bus.opCode};
         OP_LUI, OP_AUIPC:
            enc_word = {imm[31:12], bus.rd_addr, bus.opCode};
         OP_JAL:
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        bus.rd_addr, bus.opCode};
         default:
            enc_legal = 1'b0;
      endcase
   end

   // Only combinational output: ready in IDLE unless an address load is pending.
   assign bus.in_ready = (state_reg == IDLE) && !bus.load_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         addr_reg        <= BASE_ADDR;
         mem_addr_reg    <= BASE_ADDR;
         mem_wdata_reg   <= 8'h00;
         mem_we_reg      <= 1'b0;
         instr_out_reg   <= 32'h0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
         instr_count_reg <= 16'h0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.load_en) begin
                  addr_reg     <= {bus.load_addr[ADDR_W-1:2], 2'b00};
                  mem_addr_reg <= {bus.load_addr[ADDR_W-1:2], 2'b00};
               end else if (bus.in_valid) begin
                  if (enc_legal) begin
                     instr_out_reg <= enc_word;
                     state_reg     <= WR0;
                     mem_we_reg    <= 1'b1;
                     mem_addr_reg  <= addr_reg;
                     mem_wdata_reg <= enc_word[7:0];
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            WR0: if (bus.mem_ready) begin
               state_reg     <= WR1;
               mem_addr_reg  <= mem_addr_reg + ADDR_W'(1);
               mem_wdata_reg <= instr_byte[1];
            end
            WR1: if (bus.mem_ready) begin
               state_reg     <= WR2;
               mem_addr_reg  <= mem_addr_reg + ADDR_W'(1);
               mem_wdata_reg <= instr_byte[2];
            end
            WR2: if (bus.mem_ready) begin
               state_reg     <= WR3;
               mem_addr_reg  <= mem_addr_reg + ADDR_W'(1);
               mem_wdata_reg <= instr_byte[3];
            end
            WR3: if (bus.mem_ready) begin
               // Last byte accepted: commit the word and park on the next address.
               state_reg       <= IDLE;
               mem_we_reg      <= 1'b0;
               mem_wdata_reg   <= 8'h00;
               addr_reg        <= addr_reg + ADDR_W'(4);
               mem_addr_reg    <= addr_reg + ADDR_W'(4);
               instr_count_reg <= instr_count_reg + 16'd1;
               done_reg        <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.mem_we      = mem_we_reg;
   assign bus.mem_addr    = mem_addr_reg;
   assign bus.mem_wdata   = mem_wdata_reg;
   assign bus.instr_out   = instr_out_reg;
   assign bus.done        = done_reg;
   assign bus.err         = err_reg;
   assign bus.instr_count = instr_count_reg;

endmodule
